// File: rtl/stopwatch_pkg.sv
// Shared types for the stop-watch control front end.
// Run/pause/idle state encoding used by the timebase FSM.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        SW_IDLE,
        SW_RUNNING,
        SW_PAUSED
    } state_t;

endpackage

// File: rtl/button_debouncer.sv
// Raw push-button conditioner: 2-flop synchronizer, debounce counter,
// and a one-cycle pulse on each accepted rising level.
module button_debouncer
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            count    <= '0;
        end else begin
            sync1    <= btn_raw;
            sync2    <= sync1;
            stable_d <= stable;
            // Any cycle agreeing with the accepted level restarts the wait.
            if (sync2 == stable) begin
                count <= '0;
            end else if (count == LAST) begin
                stable <= sync2;
                count  <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

    assign press = stable & ~stable_d;

endmodule

// File: rtl/stopwatch_timebase.sv
// Stop-watch control front end: button conditioning, run/pause/idle FSM,
// tick prescaler and counter-clear generation.
module stopwatch_timebase
    import stopwatch_pkg::*;
#(
    parameter int DIVIDE          = 1_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_start_stop,
    input  logic btn_clear,
    output logic tick,
    output logic clear_counters,
    output logic running
);

    localparam int PW = $clog2(DIVIDE);
    localparam logic [PW-1:0] LAST = PW'(DIVIDE - 1);

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] prescaler;
    logic [PW-1:0] prescaler_next;
    logic          press_start_stop;
    logic          press_clear;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_start_stop (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_start_stop),
        .press  (press_start_stop)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clear (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_clear),
        .press  (press_clear)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SW_IDLE;
            prescaler <= '0;
        end else begin
            state     <= state_next;
            prescaler <= prescaler_next;
        end
    end

    always_comb begin
        state_next     = state;
        clear_counters = 1'b0;
        case (state)
            SW_RUNNING: begin
                // Clear is ignored while the watch runs.
                if (press_start_stop) begin
                    state_next = SW_PAUSED;
                end
            end
            SW_IDLE, SW_PAUSED: begin
                if (press_clear) begin
                    state_next     = SW_IDLE;
                    clear_counters = 1'b1;
                end else if (press_start_stop) begin
                    state_next = SW_RUNNING;
                end
            end
            default: begin
                state_next = SW_IDLE;
            end
        endcase
    end

    always_comb begin
        prescaler_next = prescaler;
        if (state == SW_RUNNING) begin
            prescaler_next = tick ? '0 : prescaler + PW'(1);
        end else if (state_next == SW_IDLE) begin
            prescaler_next = '0;
        end
    end

    assign running = (state == SW_RUNNING);
    assign tick    = running && (prescaler == LAST);

endmodule

// File: tb/tb_stopwatch_timebase.sv
// Bench for stopwatch_timebase: directed segment table plus randomized
// button activity, both checked against a behavioural model every cycle.
module tb_stopwatch_timebase;

    localparam int DIV = 4;
    localparam int DEB = 3;

    logic clk = 1'b0;
    logic reset;
    logic btn_start_stop;
    logic btn_clear;
    logic tick;
    logic clear_counters;
    logic running;

    always #5 clk = ~clk;

    stopwatch_timebase #(
        .DIVIDE         (DIV),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_start_stop(btn_start_stop),
        .btn_clear     (btn_clear),
        .tick          (tick),
        .clear_counters(clear_counters),
        .running       (running)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cycle_no    = 0;

    // Model: 0 idle, 1 running, 2 paused; run_cnt counts running cycles.
    int m_state = 0;
    int run_cnt = 0;
    bit raw_hist [2][$];
    bit syn_hist [2][$];
    bit m_stable [2];
    bit m_press  [2];
    bit e_tick, e_clr, e_run;

    // A button level is accepted once the synchronized input (raw two
    // clocks late) has disagreed with the accepted level DEB times running.
    task automatic deb_step(input int b, input bit raw);
        bit s;
        bit flip;
        s = (raw_hist[b].size() >= 2) ?
            raw_hist[b][raw_hist[b].size() - 2] : 1'b0;
        raw_hist[b].push_back(raw);
        if (raw_hist[b].size() > 2) void'(raw_hist[b].pop_front());
        syn_hist[b].push_back(s);
        if (syn_hist[b].size() > DEB) void'(syn_hist[b].pop_front());
        flip = (syn_hist[b].size() == DEB);
        foreach (syn_hist[b][i])
            if (syn_hist[b][i] == m_stable[b]) flip = 1'b0;
        m_press[b] = flip && !m_stable[b];
        if (flip) m_stable[b] = !m_stable[b];
    endtask

    task automatic model_step(input bit r, input bit s, input bit c);
        bit pss;
        bit pcl;
        if (r) begin
            m_state = 0;
            run_cnt = 0;
            for (int b = 0; b < 2; b++) begin
                raw_hist[b].delete();
                syn_hist[b].delete();
                m_stable[b] = 1'b0;
                m_press[b]  = 1'b0;
            end
        end else begin
            pss = m_press[0];
            pcl = m_press[1];
            if (m_state == 1) begin
                run_cnt++;
                if (pss) m_state = 2;
            end else if (pcl) begin
                m_state = 0;
                run_cnt = 0;
            end else if (pss) begin
                m_state = 1;
            end
            deb_step(0, s);
            deb_step(1, c);
        end
        e_run  = (m_state == 1);
        e_tick = e_run && (run_cnt % DIV == DIV - 1);
        e_clr  = m_press[1] && (m_state != 1);
    endtask

    task automatic apply(input bit r, input bit s, input bit c,
                         output bit t, output bit cc, output bit ru);
        reset          = r;
        btn_start_stop = s;
        btn_clear      = c;
        @(posedge clk);
        model_step(r, s, c);
        @(negedge clk);
        cycle_no++;
        vectors++;
        if ({tick, clear_counters, running} !== {e_tick, e_clr, e_run}) begin
            miscompares++;
            $display("FAIL cycle %0d outputs: tick/clear/running got %b%b%b expected %b%b%b",
                     cycle_no, tick, clear_counters, running,
                     e_tick, e_clr, e_run);
        end
        t  = tick;
        cc = clear_counters;
        ru = running;
    endtask

    typedef struct {
        string name;
        bit    rst;
        bit    ss;
        bit    cl;
        int    n;
        bit    run;
        int    ticks;
        int    clears;
    } seg_t;

    seg_t segs[$];

    initial begin
        bit t, cc, ru;
        int nt, nc;
        bit s, c;
        int len;

        reset          = 1'b1;
        btn_start_stop = 1'b0;
        btn_clear      = 1'b0;

        segs.push_back('{"reset",       1, 0, 0,  2, 0, 0, 0});
        segs.push_back('{"idle",        0, 0, 0, 20, 0, 0, 0});
        segs.push_back('{"glitch_hi",   0, 1, 0,  2, 0, 0, 0});
        segs.push_back('{"glitch_lo",   0, 0, 0,  8, 0, 0, 0});
        segs.push_back('{"start_a",     0, 1, 0,  5, 0, 0, 0});
        segs.push_back('{"start_b",     0, 1, 0,  5, 1, 1, 0});
        segs.push_back('{"run_free",    0, 0, 0, 12, 1, 3, 0});
        segs.push_back('{"pause_a",     0, 1, 0,  6, 0, 1, 0});
        segs.push_back('{"paused",      0, 0, 0, 10, 0, 0, 0});
        segs.push_back('{"resume_a",    0, 1, 0,  6, 1, 0, 0});
        segs.push_back('{"resume_b",    0, 0, 0,  2, 1, 1, 0});
        segs.push_back('{"clr_run_a",   0, 0, 1,  6, 1, 1, 0});
        segs.push_back('{"clr_run_b",   0, 0, 0,  6, 1, 2, 0});
        segs.push_back('{"pause2_a",    0, 1, 0,  6, 0, 1, 0});
        segs.push_back('{"pause2_b",    0, 0, 0,  6, 0, 0, 0});
        segs.push_back('{"clr_pause_a", 0, 0, 1,  6, 0, 0, 1});
        segs.push_back('{"clr_pause_b", 0, 0, 0,  6, 0, 0, 0});
        segs.push_back('{"restart_a",   0, 1, 0,  6, 1, 0, 0});
        segs.push_back('{"restart_b",   0, 0, 0,  4, 1, 1, 0});
        segs.push_back('{"pause3_a",    0, 1, 0,  6, 0, 1, 0});
        segs.push_back('{"pause3_b",    0, 0, 0,  6, 0, 0, 0});
        segs.push_back('{"both_a",      0, 1, 1,  6, 0, 0, 1});
        segs.push_back('{"both_b",      0, 0, 0,  6, 0, 0, 0});
        segs.push_back('{"start4_a",    0, 1, 0,  6, 1, 0, 0});
        segs.push_back('{"start4_b",    0, 0, 0,  3, 1, 1, 0});
        segs.push_back('{"mid_reset",   1, 0, 0,  1, 0, 0, 0});
        segs.push_back('{"post_reset",  0, 0, 0, 10, 0, 0, 0});

        foreach (segs[i]) begin
            nt = 0;
            nc = 0;
            ru = 1'b0;
            for (int j = 0; j < segs[i].n; j++) begin
                apply(segs[i].rst, segs[i].ss, segs[i].cl, t, cc, ru);
                nt += int'(t);
                nc += int'(cc);
            end
            vectors++;
            if (ru !== segs[i].run || nt != segs[i].ticks ||
                nc != segs[i].clears) begin
                miscompares++;
                $display("FAIL segment %s: running/ticks/clears got %b/%0d/%0d expected %b/%0d/%0d",
                         segs[i].name, ru, nt, nc,
                         segs[i].run, segs[i].ticks, segs[i].clears);
            end
        end

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                apply(1'b1, 1'b0, 1'b0, t, cc, ru);
            end else begin
                s   = 1'($urandom_range(0, 1));
                c   = ($urandom_range(0, 3) == 0);
                len = int'($urandom_range(1, 7));
                for (int j = 0; j < len; j++)
                    apply(1'b0, s, c, t, cc, ru);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
